croc_pad_ctrl: RTL

- Per-pad ownership controller for the bidirectional I/O pad ring. Each pad is owned either by its SoC function (UART TX, status, JTAG TDO) or by software GPIO.
- Sequences each ownership change with a break-before-make turnaround so two drivers never fight on a pad.
- Synchronizes pad inputs, raises rising-edge interrupts, and exposes a small word-addressed register interface.
- Sits between the SoC peripherals and the pad-cell DIN/OEN/DOUT pins in the chip top.

---
 rtl/croc_pkg.sv | 20 ++
 rtl/croc_pad_seq.sv | 103 ++++++++++
 rtl/croc_pad_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/croc_pkg.sv
// Shared types and register offsets for the pad ownership controller.
// Imported by the controller top and the per-pad sequencer.
package croc_pkg;

  typedef enum logic [1:0] {
    FUNC   = 2'd0,
    TURN_G = 2'd1,
    GPIO   = 2'd2,
    TURN_F = 2'd3
  } pad_state_e;

  localparam logic [2:0] PadOwnerOffs   = 3'd0;
  localparam logic [2:0] PadOutOffs     = 3'd1;
  localparam logic [2:0] PadOeOffs      = 3'd2;
  localparam logic [2:0] PadInOffs      = 3'd3;
  localparam logic [2:0] PadIrqEnOffs   = 3'd4;
  localparam logic [2:0] PadIrqStatOffs = 3'd5;
  localparam logic [2:0] PadTurnOffs    = 3'd6;

endpackage

// File: rtl/croc_pad_seq.sv
// Per-pad ownership sequencer with break-before-make turnaround.
// The pad is held high-Z for TurnCycles cycles on every owner change.
module croc_pad_seq
  import croc_pkg::*;
#(
  parameter int unsigned TurnCycles = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic owner_i,
  input  logic func_out_i,
  input  logic func_oe_i,
  input  logic gpio_out_i,
  input  logic gpio_oe_i,
  output logic pad_din_o,
  output logic pad_oen_o,
  output logic func_sel_o,
  output logic busy_o
);

  localparam int unsigned CntW = $clog2(TurnCycles + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(TurnCycles - 1);

  pad_state_e state;
  logic [CntW-1:0] cnt;

  // Ownership FSM; busy is registered alongside the state it mirrors
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= FUNC;
      cnt    <= '0;
      busy_o <= 1'b0;
    end else begin
      unique case (state)
        FUNC: begin
          if (owner_i) begin
            state  <= TURN_G;
            cnt    <= CntLoad;
            busy_o <= 1'b1;
          end
        end
        TURN_G: begin
          if (!owner_i) begin
            state <= TURN_F;
            cnt   <= CntLoad;
          end else if (cnt == '0) begin
            state  <= GPIO;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        GPIO: begin
          if (!owner_i) begin
            state  <= TURN_F;
            cnt    <= CntLoad;
            busy_o <= 1'b1;
          end
        end
        TURN_F: begin
          if (owner_i) begin
            state <= TURN_G;
            cnt   <= CntLoad;
          end else if (cnt == '0) begin
            state  <= FUNC;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        default: begin
          state  <= FUNC;
          cnt    <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Pad drive select; turnaround states float the pad
  always_comb begin
    pad_din_o  = 1'b0;
    pad_oen_o  = 1'b1;
    func_sel_o = 1'b0;
    unique case (state)
      FUNC: begin
        pad_din_o  = func_out_i;
        pad_oen_o  = ~func_oe_i;
        func_sel_o = 1'b1;
      end
      GPIO: begin
        pad_din_o = gpio_out_i;
        pad_oen_o = ~gpio_oe_i;
      end
      default: begin
        pad_din_o  = 1'b0;
        pad_oen_o  = 1'b1;
        func_sel_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/croc_pad_ctrl.sv
// Pad ring ownership controller: register file, input sync, IRQs.
// One croc_pad_seq per pad arbitrates function vs GPIO drive.
module croc_pad_ctrl
  import croc_pkg::*;
#(
  parameter int unsigned       NumPads    = 8,
  parameter int unsigned       TurnCycles = 2,
  parameter logic [NumPads-1:0] FuncIdle  = '1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               reg_req_i,
  input  logic               reg_we_i,
  input  logic [2:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               reg_rvalid_o,
  input  logic [NumPads-1:0] func_out_i,
  input  logic [NumPads-1:0] func_oe_i,
  output logic [NumPads-1:0] func_in_o,
  output logic [NumPads-1:0] pad_din_o,
  output logic [NumPads-1:0] pad_oen_o,
  input  logic [NumPads-1:0] pad_dout_i,
  output logic               irq_o
);

  logic [NumPads-1:0] owner;
  logic [NumPads-1:0] gpio_out;
  logic [NumPads-1:0] gpio_oe;
  logic [NumPads-1:0] irq_en;
  logic [NumPads-1:0] irq_stat;
  logic [NumPads-1:0] sync1;
  logic [NumPads-1:0] sync2;
  logic [NumPads-1:0] sync_q;
  logic [NumPads-1:0] rise;
  logic [NumPads-1:0] irq_clr;
  logic [NumPads-1:0] busy;
  logic [NumPads-1:0] func_sel;
  logic [NumPads-1:0] wdata;
  logic [31:0]        rdata;
  logic               wr_en;
  logic               unused_wdata;

  assign wr_en   = reg_req_i && reg_we_i;
  assign wdata   = reg_wdata_i[NumPads-1:0];
  assign rise    = sync2 & ~sync_q;
  assign irq_clr = (wr_en && reg_addr_i == PadIrqStatOffs) ? wdata : '0;
  assign irq_o   = |(irq_stat & irq_en);
  assign unused_wdata = ^reg_wdata_i;

  assign func_in_o = (func_sel & pad_dout_i) | (~func_sel & FuncIdle);

  // Two-flop input synchronizer plus edge-detect history
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1  <= '0;
      sync2  <= '0;
      sync_q <= '0;
    end else begin
      sync1  <= pad_dout_i;
      sync2  <= sync1;
      sync_q <= sync2;
    end
  end

  // Register writes; a same-cycle edge beats the W1C clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner    <= '0;
      gpio_out <= '0;
      gpio_oe  <= '0;
      irq_en   <= '0;
      irq_stat <= '0;
    end else begin
      if (wr_en) begin
        case (reg_addr_i)
          PadOwnerOffs: owner    <= wdata;
          PadOutOffs:   gpio_out <= wdata;
          PadOeOffs:    gpio_oe  <= wdata;
          PadIrqEnOffs: irq_en   <= wdata;
          default: ;
        endcase
      end
      irq_stat <= (irq_stat & ~irq_clr) | (rise & irq_en);
    end
  end

  // Read data mux
  always_comb begin
    rdata = '0;
    case (reg_addr_i)
      PadOwnerOffs:   rdata = 32'(owner);
      PadOutOffs:     rdata = 32'(gpio_out);
      PadOeOffs:      rdata = 32'(gpio_oe);
      PadInOffs:      rdata = 32'(sync2);
      PadIrqEnOffs:   rdata = 32'(irq_en);
      PadIrqStatOffs: rdata = 32'(irq_stat);
      PadTurnOffs:    rdata = 32'(busy);
      default:        rdata = '0;
    endcase
  end

  // One-cycle response; writes return zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_rvalid_o <= 1'b0;
      reg_rdata_o  <= '0;
    end else begin
      reg_rvalid_o <= reg_req_i;
      reg_rdata_o  <= (reg_req_i && !reg_we_i) ? rdata : '0;
    end
  end

  for (genvar i = 0; i < NumPads; i++) begin : g_pad
    croc_pad_seq #(
      .TurnCycles (TurnCycles)
    ) u_seq (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .owner_i    (owner[i]),
      .func_out_i (func_out_i[i]),
      .func_oe_i  (func_oe_i[i]),
      .gpio_out_i (gpio_out[i]),
      .gpio_oe_i  (gpio_oe[i]),
      .pad_din_o  (pad_din_o[i]),
      .pad_oen_o  (pad_oen_o[i]),
      .func_sel_o (func_sel[i]),
      .busy_o     (busy[i])
    );
  end

endmodule
